mem_load_ctrl: RTL and testbench
================================

// Module: mem_load_ctrl
// PURPOSE
// Hardware host for the processor's external memory port: streams instruction words into IRAM and data
// words into DRAM, starts the processor, waits for completion/timeout, then reads the result window
// back out of DRAM. Drives addr_ext, write/read enables and start..start_4 mode selects of top_control.
// PARAMETERS
// SETUP_CYC 2 cycles data/addr stable with write enable low before each write
// WR_CYC    4 cycles write enable held high per word
// GAP_CYC   4 cycles write enable low after each write before addr increments
// RD_CYC    5 cycles read_en_ext high before dram_rd_data is sampled
// PORTS
// clock          in  1  system clock, all logic on rising edge
// reset_n        in  1  asynchronous active-low reset
// go             in  1  1-cycle pulse: start a full load/run/readback sequence (ignored while busy)
// iram_count     in  9  instruction words to load (sampled on go)
// dram_count     in  9  data words to load (sampled on go)
// final_start    in  9  first DRAM address of result window (sampled on go)
// final_end      in  9  result window end, exclusive (sampled on go)
// run_cycles     in  24 run timeout in cycles (sampled on go)
// in_valid       in  1  load-word stream valid
// in_data        in  16 load-word stream data (IRAM words first, then DRAM words)
// in_ready       out 1  load-word stream ready
// out_valid      out 1  result stream valid
// out_data       out 16 result word
// out_ready      in  1  result stream ready
// proc_done      in  1  processor finished (level)
// dram_rd_data   in  16 DRAM read data (dram_in of top_control)
// addr_ext       out 9  external memory address
// Data_in_ins    out 16 IRAM write data
// Data_in_dram   out 16 DRAM write data
// iram_write_ext out 1  IRAM write enable
// dram_write_ext out 1  DRAM write enable
// read_en_ext    out 1  DRAM external read enable
// start,start_2,start_3,start_4 out 1 each: run / IRAM-load / DRAM-load / readback mode selects
// busy           out 1  sequence in progress
// done           out 1  1-cycle pulse at end of sequence
// timeout        out 1  last run ended by run_cycles, not proc_done; cleared on go
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, counters 0; reset mid-sequence aborts immediately, no done.
// - States: IDLE, I_FETCH, I_SETUP, I_WRITE, I_GAP, SW1, D_FETCH, D_SETUP, D_WRITE, D_GAP, SW2, RUN,
//   SW3, RB_READ, RB_SEND, FINISH.
// - IDLE: go -> latch config, busy=1, addr_ext=1, start_2=1, -> I_FETCH (SW1 if iram_count=0).
// - x_FETCH: in_ready=1; on in_valid&in_ready latch in_data to Data_in_ins/Data_in_dram -> x_SETUP.
// - x_SETUP SETUP_CYC cycles we=0; x_WRITE WR_CYC cycles we=1; x_GAP GAP_CYC cycles we=0, then
//   addr_ext+1; words_done+1; if words_done==count -> SWn else x_FETCH. Data/addr stable SETUP..GAP.
// - Mode selects one-hot; each SWn is one cycle with all four low. SW1: addr_ext=1 -> D_FETCH,
//   start_3=1 (SW2 if dram_count=0). SW2 -> RUN, start=1, run counter cleared.
// - RUN: exit when proc_done=1 (timeout=0) or counter==run_cycles (timeout=1); both same cycle:
//   proc_done wins. run_cycles=0 -> exit after 1 cycle with timeout=1 unless proc_done.
// - SW3: addr_ext=final_start, start_4=1; final_start>=final_end -> FINISH directly.
// - RB_READ: read_en_ext=1 RD_CYC cycles, sample dram_rd_data into out_data on last cycle.
// - RB_SEND: read_en_ext=0, out_valid=1, out_data stable until out_ready; then addr_ext+1;
//   addr_ext<final_end -> RB_READ else FINISH. Address arithmetic 9-bit, no wrap past 511 (stop).
// - FINISH: all selects/enables 0, done=1 one cycle, busy=0 -> IDLE. in_ready/out_valid 0 outside
//   FETCH/SEND states; extra in_data words are not accepted.
// TESTING
// - iram_count=3 words 10,20,30 -> writes at addr 1,2,3; each we high exactly 4 cycles, start_2 only.
// - dram_count=2 (5,7), proc_done at run cycle 50 -> DRAM writes addr 1,2, start high 50 cycles, timeout=0.
// - proc_done never, run_cycles=100 -> RUN exits at cycle 100, timeout=1, readback proceeds.
// - final_start=4, final_end=7, DRAM model 4..6=11,12,13, out_ready stalls 3 cycles -> out 11,12,13, done.
// - iram_count=0,dram_count=0,final_start=final_end -> only RUN; check one-hot selects and SW gaps.
// - reset_n low during D_WRITE -> all outputs 0 at once; new go restarts at addr 1 with start_2.

Source files
------------

// File: rtl/mem_load_ctrl.sv
// External memory host: streams words into IRAM then DRAM, runs the processor
// until proc_done or a cycle limit, then streams a DRAM result window back out.
module mem_load_ctrl #(
  parameter int SETUP_CYC = 2,
  parameter int WR_CYC    = 4,
  parameter int GAP_CYC   = 4,
  parameter int RD_CYC    = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        go,
  input  logic [8:0]  iram_count,
  input  logic [8:0]  dram_count,
  input  logic [8:0]  final_start,
  input  logic [8:0]  final_end,
  input  logic [23:0] run_cycles,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  input  logic        proc_done,
  input  logic [15:0] dram_rd_data,
  output logic [8:0]  addr_ext,
  output logic [15:0] Data_in_ins,
  output logic [15:0] Data_in_dram,
  output logic        iram_write_ext,
  output logic        dram_write_ext,
  output logic        read_en_ext,
  output logic        start,
  output logic        start_2,
  output logic        start_3,
  output logic        start_4,
  output logic        busy,
  output logic        done,
  output logic        timeout
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_I_FETCH = 4'd1;
  localparam logic [3:0] S_I_SETUP = 4'd2;
  localparam logic [3:0] S_I_WRITE = 4'd3;
  localparam logic [3:0] S_I_GAP   = 4'd4;
  localparam logic [3:0] S_SW1     = 4'd5;
  localparam logic [3:0] S_D_FETCH = 4'd6;
  localparam logic [3:0] S_D_SETUP = 4'd7;
  localparam logic [3:0] S_D_WRITE = 4'd8;
  localparam logic [3:0] S_D_GAP   = 4'd9;
  localparam logic [3:0] S_SW2     = 4'd10;
  localparam logic [3:0] S_RUN     = 4'd11;
  localparam logic [3:0] S_SW3     = 4'd12;
  localparam logic [3:0] S_RB_READ = 4'd13;
  localparam logic [3:0] S_RB_SEND = 4'd14;
  localparam logic [3:0] S_FINISH  = 4'd15;

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0] WR_LAST    = 8'(WR_CYC - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);
  localparam logic [7:0] RD_LAST    = 8'(RD_CYC - 1);

  logic [3:0]  state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [8:0]  addr_q, addr_d;
  logic [8:0]  words_q, words_d;
  logic [8:0]  icnt_q, icnt_d;
  logic [8:0]  dcnt_q, dcnt_d;
  logic [8:0]  fstart_q, fstart_d;
  logic [8:0]  fend_q, fend_d;
  logic [23:0] run_cfg_q, run_cfg_d;
  logic [23:0] run_cnt_q, run_cnt_d;
  logic [15:0] din_ins_q, din_ins_d;
  logic [15:0] din_dram_q, din_dram_d;
  logic [15:0] out_data_q, out_data_d;
  logic        timeout_q, timeout_d;

  logic        load_iram;
  logic [8:0]  load_count;
  logic [8:0]  addr_inc;
  logic [8:0]  words_inc;
  logic        run_limit;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    addr_d     = addr_q;
    words_d    = words_q;
    icnt_d     = icnt_q;
    dcnt_d     = dcnt_q;
    fstart_d   = fstart_q;
    fend_d     = fend_q;
    run_cfg_d  = run_cfg_q;
    run_cnt_d  = run_cnt_q;
    din_ins_d  = din_ins_q;
    din_dram_d = din_dram_q;
    out_data_d = out_data_q;
    timeout_d  = timeout_q;

    // Address saturates at the top of the 9-bit space instead of wrapping.
    addr_inc   = (addr_q == 9'h1FF) ? addr_q : addr_q + 9'd1;
    words_inc  = words_q + 9'd1;
    load_iram  = (state_q == S_I_FETCH) || (state_q == S_I_SETUP) ||
                 (state_q == S_I_WRITE) || (state_q == S_I_GAP);
    load_count = load_iram ? icnt_q : dcnt_q;
    run_limit  = ({1'b0, run_cnt_q} + 25'd1) >= {1'b0, run_cfg_q};

    case (state_q)
      S_IDLE: begin
        if (go) begin
          icnt_d    = iram_count;
          dcnt_d    = dram_count;
          fstart_d  = final_start;
          fend_d    = final_end;
          run_cfg_d = run_cycles;
          timeout_d = 1'b0;
          addr_d    = 9'd1;
          words_d   = '0;
          state_d   = (iram_count == 9'd0) ? S_SW1 : S_I_FETCH;
        end
      end
      S_I_FETCH, S_D_FETCH: begin
        if (in_valid) begin
          if (load_iram) din_ins_d = in_data;
          else           din_dram_d = in_data;
          phase_d = '0;
          state_d = load_iram ? S_I_SETUP : S_D_SETUP;
        end
      end
      S_I_SETUP, S_D_SETUP: begin
        if (phase_q == SETUP_LAST) begin
          phase_d = '0;
          state_d = load_iram ? S_I_WRITE : S_D_WRITE;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      S_I_WRITE, S_D_WRITE: begin
        if (phase_q == WR_LAST) begin
          phase_d = '0;
          state_d = load_iram ? S_I_GAP : S_D_GAP;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      S_I_GAP, S_D_GAP: begin
        if (phase_q == GAP_LAST) begin
          phase_d = '0;
          addr_d  = addr_inc;
          words_d = words_inc;
          if (words_inc == load_count) state_d = load_iram ? S_SW1 : S_SW2;
          else                         state_d = load_iram ? S_I_FETCH : S_D_FETCH;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      S_SW1: begin
        addr_d  = 9'd1;
        words_d = '0;
        state_d = (dcnt_q == 9'd0) ? S_SW2 : S_D_FETCH;
      end
      S_SW2: begin
        run_cnt_d = '0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        run_cnt_d = run_cnt_q + 24'd1;
        // A proc_done arriving on the limit cycle still counts as a clean finish.
        if (proc_done) begin
          timeout_d = 1'b0;
          state_d   = S_SW3;
        end else if (run_limit) begin
          timeout_d = 1'b1;
          state_d   = S_SW3;
        end
      end
      S_SW3: begin
        addr_d  = fstart_q;
        phase_d = '0;
        state_d = (fstart_q < fend_q) ? S_RB_READ : S_FINISH;
      end
      S_RB_READ: begin
        if (phase_q == RD_LAST) begin
          out_data_d = dram_rd_data;
          phase_d    = '0;
          state_d    = S_RB_SEND;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      S_RB_SEND: begin
        if (out_ready) begin
          addr_d  = addr_inc;
          state_d = (addr_q != 9'h1FF && addr_inc < fend_q) ? S_RB_READ : S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      addr_q     <= '0;
      words_q    <= '0;
      icnt_q     <= '0;
      dcnt_q     <= '0;
      fstart_q   <= '0;
      fend_q     <= '0;
      run_cfg_q  <= '0;
      run_cnt_q  <= '0;
      din_ins_q  <= '0;
      din_dram_q <= '0;
      out_data_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
      icnt_q     <= icnt_d;
      dcnt_q     <= dcnt_d;
      fstart_q   <= fstart_d;
      fend_q     <= fend_d;
      run_cfg_q  <= run_cfg_d;
      run_cnt_q  <= run_cnt_d;
      din_ins_q  <= din_ins_d;
      din_dram_q <= din_dram_d;
      out_data_q <= out_data_d;
      timeout_q  <= timeout_d;
    end
  end

  // Handshakes, enables and mode selects decode straight from the state so
  // the SWn cycles naturally drop every select.
  assign in_ready       = (state_q == S_I_FETCH) || (state_q == S_D_FETCH);
  assign out_valid      = (state_q == S_RB_SEND);
  assign out_data       = out_data_q;
  assign addr_ext       = addr_q;
  assign Data_in_ins    = din_ins_q;
  assign Data_in_dram   = din_dram_q;
  assign iram_write_ext = (state_q == S_I_WRITE);
  assign dram_write_ext = (state_q == S_D_WRITE);
  assign read_en_ext    = (state_q == S_RB_READ);
  assign start          = (state_q == S_RUN);
  assign start_2        = load_iram;
  assign start_3        = (state_q == S_D_FETCH) || (state_q == S_D_SETUP) ||
                          (state_q == S_D_WRITE) || (state_q == S_D_GAP);
  assign start_4        = (state_q == S_RB_READ) || (state_q == S_RB_SEND);
  assign busy           = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign done           = (state_q == S_FINISH);
  assign timeout        = timeout_q;

endmodule

// File: tb/tb_mem_load_ctrl.sv
// Scoreboard bench for mem_load_ctrl: a sequence-level model queues expected
// memory writes, run length/timeout and readback words; a monitor checks them.
module tb_mem_load_ctrl;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        go = 1'b0;
  logic [8:0]  iram_count = '0, dram_count = '0, final_start = '0, final_end = '0;
  logic [23:0] run_cycles = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, out_valid, out_ready = 1'b0, proc_done;
  logic [15:0] out_data, dram_rd_data, Data_in_ins, Data_in_dram;
  logic [8:0]  addr_ext;
  logic        iram_write_ext, dram_write_ext, read_en_ext;
  logic        start, start_2, start_3, start_4, busy, done, timeout;

  always #5 clock = ~clock;

  mem_load_ctrl dut (
    .clock(clock), .reset_n(reset_n), .go(go),
    .iram_count(iram_count), .dram_count(dram_count),
    .final_start(final_start), .final_end(final_end), .run_cycles(run_cycles),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .proc_done(proc_done), .dram_rd_data(dram_rd_data), .addr_ext(addr_ext),
    .Data_in_ins(Data_in_ins), .Data_in_dram(Data_in_dram),
    .iram_write_ext(iram_write_ext), .dram_write_ext(dram_write_ext),
    .read_en_ext(read_en_ext), .start(start), .start_2(start_2),
    .start_3(start_3), .start_4(start_4), .busy(busy), .done(done),
    .timeout(timeout)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Power-on DRAM contents; addresses 4..6 hold 11,12,13.
  function automatic logic [15:0] init_val(input int a);
    if (a >= 4 && a <= 6) return 16'(a + 7);
    return 16'(a * 40503) ^ 16'h5A5A;
  endfunction

  // Physical DRAM seen by the DUT, plus a processor that raises proc_done.
  logic [15:0] phys_dram [512];
  bit          phys_valid [512];
  int          rd_cnt = 0;
  int          run_ctr = 0;
  bit          pd_en = 1'b0;
  int          pd_at = 1;
  bit          stall_mode = 1'b0;

  always @(posedge clock) begin
    if (dram_write_ext) begin
      phys_dram[addr_ext]  <= Data_in_dram;
      phys_valid[addr_ext] <= 1'b1;
    end
    rd_cnt  <= read_en_ext ? rd_cnt + 1 : 0;
    run_ctr <= start ? run_ctr + 1 : 0;
  end

  // Read data is only valid once read_en_ext has been held for five cycles.
  assign dram_rd_data = (read_en_ext && rd_cnt >= 4) ?
                        (phys_valid[addr_ext] ? phys_dram[addr_ext] : init_val(int'(addr_ext))) :
                        16'hBAD0;
  assign proc_done = pd_en && start && (run_ctr + 1 >= pd_at);

  // Reference model state and expectation queues.
  typedef struct packed { logic [8:0] a; logic [15:0] d; } wr_t;
  logic [15:0] ref_dram [512];
  wr_t         exp_iw[$];
  wr_t         exp_dw[$];
  int          exp_run_len[$];
  bit          exp_run_to[$];
  logic [15:0] exp_out[$];
  logic [15:0] words_i[$];
  logic [15:0] words_d[$];

  // Monitor state.
  int          cyc = 0, last_hs = 0, last_we = 0, viol = 0, done_cnt = 0;
  bit          we_on [2];
  int          we_len [2];
  logic [8:0]  we_a [2];
  logic [15:0] we_d [2];
  logic        we_now [2];
  logic [15:0] d_now [2];
  bit          run_on = 0, rd_on = 0;
  int          run_len = 0, rd_len = 0, r_len = 0;
  bit          r_to;
  bit          p_valid = 0, p_hs = 0, p_done = 0, p_load = 0;
  logic [15:0] p_data = '0, o_exp;
  logic [8:0]  p_addr = '0;
  logic [3:0]  sel, p_sel = '0;
  wr_t         m_e;

  always @(negedge clock) begin
    cyc++;
    if (!reset_n) begin
      we_on[0] = 0; we_on[1] = 0; run_on = 0; rd_on = 0;
      p_valid = 0; p_hs = 0; p_done = 0; p_load = 0; p_sel = '0; p_addr = '0;
    end else begin
      sel = {start, start_2, start_3, start_4};
      if ($countones(sel) > 1) viol++;
      if (sel != 4'd0 && p_sel != 4'd0 && sel != p_sel) viol++;
      if (in_ready && !(start_2 || start_3)) viol++;
      if (out_valid && !start_4) viol++;
      if (in_valid && in_ready) last_hs = cyc;

      we_now[0] = iram_write_ext; we_now[1] = dram_write_ext;
      d_now[0]  = Data_in_ins;    d_now[1]  = Data_in_dram;
      for (int k = 0; k < 2; k++) begin
        if (we_now[k] && !we_on[k]) begin
          we_on[k] = 1; we_len[k] = 1; we_a[k] = addr_ext; we_d[k] = d_now[k];
          check(k == 1 ? "d_setup_cycles" : "i_setup_cycles", cyc - last_hs, 3);
        end else if (we_now[k]) begin
          we_len[k]++;
          if (addr_ext != we_a[k] || d_now[k] != we_d[k]) viol++;
        end else if (we_on[k]) begin
          we_on[k] = 0;
          last_we  = cyc - 1;
          if ((k == 0 ? exp_iw.size() : exp_dw.size()) == 0) begin
            check(k == 1 ? "d_unexpected_write" : "i_unexpected_write", 1, 0);
          end else begin
            m_e = (k == 0) ? exp_iw.pop_front() : exp_dw.pop_front();
            check(k == 1 ? "d_write_addr" : "i_write_addr", we_a[k], m_e.a);
            check(k == 1 ? "d_write_data" : "i_write_data", we_d[k], m_e.d);
            check(k == 1 ? "d_we_cycles" : "i_we_cycles", we_len[k], 4);
          end
        end
      end
      if (addr_ext != p_addr && p_load) check("gap_cycles", cyc - last_we, 5);

      if (start && !run_on) begin run_on = 1; run_len = 1; end
      else if (start) run_len++;
      else if (run_on) begin
        run_on = 0;
        if (exp_run_len.size() == 0) check("unexpected_run", 1, 0);
        else begin
          r_len = exp_run_len.pop_front();
          r_to  = exp_run_to.pop_front();
          check("run_cycles", run_len, r_len);
          check("timeout_flag", timeout, r_to);
        end
      end

      if (read_en_ext && !rd_on) begin rd_on = 1; rd_len = 1; end
      else if (read_en_ext) rd_len++;
      else if (rd_on) begin rd_on = 0; check("read_en_cycles", rd_len, 5); end

      if (out_valid && p_valid && !p_hs && out_data != p_data) viol++;
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) check("unexpected_out", 1, 0);
        else begin
          o_exp = exp_out.pop_front();
          check("out_data", out_data, o_exp);
        end
      end

      if (done) begin
        if (p_done) viol++;
        check("done_busy", busy, 0);
        done_cnt++;
      end

      p_valid = out_valid; p_hs = out_valid && out_ready; p_data = out_data;
      p_done = done; p_sel = sel; p_addr = addr_ext; p_load = start_2 || start_3;
    end
  end

  // Result-stream consumer: random back-pressure, or a fixed 3-cycle stall.
  initial begin
    int vcnt;
    vcnt = 0;
    forever begin
      @(negedge clock);
      if (out_valid && !out_ready) vcnt++;
      else vcnt = 0;
      @(posedge clock); #1;
      out_ready = stall_mode ? (vcnt >= 3) : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check_idle_outs();
    check("rst_selects", {start, start_2, start_3, start_4}, 0);
    check("rst_enables", {iram_write_ext, dram_write_ext, read_en_ext}, 0);
    check("rst_addr", addr_ext, 0);
    check("rst_wdata", {Data_in_ins, Data_in_dram}, 0);
    check("rst_handshake", {in_ready, out_valid}, 0);
    check("rst_out_data", out_data, 0);
    check("rst_flags", {busy, done, timeout}, 0);
  endtask

  task automatic feed(input logic [15:0] w);
    bit hs;
    hs = 0;
    in_valid = 1'b1;
    in_data  = w;
    for (int c = 0; c < 300 && !hs; c++) begin
      @(negedge clock);
      hs = in_ready;
      @(posedge clock); #1;
    end
    if (!hs) check("in_handshake", 0, 1);
  endtask

  task automatic fill_rand(input int ic, input int dc);
    words_i.delete();
    words_d.delete();
    for (int i = 0; i < ic; i++) words_i.push_back(16'($urandom));
    for (int i = 0; i < dc; i++) words_d.push_back(16'($urandom));
  endtask

  task automatic go_pulse(input int ic, input int dc, input int fs, input int fe, input int rc);
    @(posedge clock); #1;
    iram_count = 9'(ic); dram_count = 9'(dc);
    final_start = 9'(fs); final_end = 9'(fe); run_cycles = 24'(rc);
    in_valid = 1'b0;
    go = 1'b1;
    @(posedge clock); #1;
    go = 1'b0;
  endtask

  task automatic clear_queues();
    exp_iw.delete(); exp_dw.delete(); exp_out.delete();
    exp_run_len.delete(); exp_run_to.delete();
  endtask

  task automatic run_seq(input int fs, input int fe, input int rc,
                         input bit pen, input int pat, input bit stall);
    wr_t e;
    int  eff, len, d0, ic, dc;
    bit  to;
    ic = words_i.size();
    dc = words_d.size();
    for (int i = 0; i < ic; i++) begin e.a = 9'(i + 1); e.d = words_i[i]; exp_iw.push_back(e); end
    for (int i = 0; i < dc; i++) begin
      e.a = 9'(i + 1); e.d = words_d[i]; exp_dw.push_back(e);
      ref_dram[i + 1] = words_d[i];
    end
    eff = (rc == 0) ? 1 : rc;
    if (pen && pat <= eff) begin len = pat; to = 0; end
    else begin len = eff; to = 1; end
    exp_run_len.push_back(len);
    exp_run_to.push_back(to);
    for (int a = fs; a < fe; a++) exp_out.push_back(ref_dram[a]);
    pd_en = pen; pd_at = pat; stall_mode = stall;
    $display("seq: ic=%0d dc=%0d window=[%0d,%0d) run_cycles=%0d proc_done_at=%0d -> run %0d timeout %0d",
             ic, dc, fs, fe, rc, pen ? pat : -1, len, to);
    d0 = done_cnt;
    go_pulse(ic, dc, fs, fe, rc);
    @(negedge clock);
    check("busy_after_go", busy, 1);
    check("timeout_cleared", timeout, 0);
    check("first_select", {start, start_2, start_3, start_4}, ic > 0 ? 4'b0100 : 4'b0000);
    @(posedge clock); #1;
    for (int i = 0; i < ic; i++) feed(words_i[i]);
    for (int i = 0; i < dc; i++) feed(words_d[i]);
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    for (int c = 0; c < 5000 && done_cnt == d0; c++) begin @(negedge clock); #1; end
    check("sequence_done", done_cnt - d0, 1);
    in_valid = 1'b0;
    check("leftover_expectations",
          exp_iw.size() + exp_dw.size() + exp_out.size() + exp_run_len.size(), 0);
    clear_queues();
  endtask

  initial begin
    int ic, dc, fs, fe;
    for (int a = 0; a < 512; a++) ref_dram[a] = init_val(a);

    repeat (3) @(negedge clock);
    check_idle_outs();
    #2 reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Fixed load pattern, proc_done at run cycle 50, stalled readback of 4..6.
    words_i = {16'd10, 16'd20, 16'd30};
    words_d = {16'd5, 16'd7};
    run_seq(4, 7, 1000, 1, 50, 1);
    // No proc_done: timeout after 100 cycles, read back the loaded words.
    fill_rand(1, 1);
    run_seq(1, 3, 100, 0, 1, 0);
    // Run-only sequences, including run_cycles=0 and an empty window.
    fill_rand(0, 0);
    run_seq(5, 5, 20, 0, 1, 0);
    fill_rand(0, 0);
    run_seq(3, 4, 0, 0, 1, 0);
    // proc_done on the limit cycle wins; inverted window skips readback.
    fill_rand(1, 0);
    run_seq(9, 3, 10, 1, 10, 0);

    // Reset in the middle of a DRAM write.
    words_i = {16'h00AA};
    clear_queues();
    exp_iw.push_back(wr_t'{a: 9'd1, d: 16'h00AA});
    pd_en = 0;
    stall_mode = 0;
    go_pulse(1, 2, 0, 0, 100);
    @(posedge clock); #1;
    feed(16'h00AA);
    feed(16'h0BB0);
    in_valid = 1'b0;
    for (int c = 0; c < 200 && !dram_write_ext; c++) @(negedge clock);
    check("reach_dram_write", dram_write_ext, 1);
    @(negedge clock); #2;
    reset_n = 1'b0;
    #1;
    $display("reset asserted during DRAM write");
    check_idle_outs();
    check("iram_write_before_reset", exp_iw.size(), 0);
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b1;
    clear_queues();
    fill_rand(2, 2);
    run_seq(1, 3, 15, 1, 7, 0);

    // Randomized sequences.
    for (int s = 0; s < 8; s++) begin
      ic = $urandom_range(0, 4);
      dc = $urandom_range(0, 4);
      fs = $urandom_range(0, 12);
      fe = ($urandom_range(0, 4) == 0) ? fs / 2 : fs + $urandom_range(0, 4);
      fill_rand(ic, dc);
      run_seq(fs, fe, $urandom_range(0, 40), bit'($urandom_range(0, 1)),
              $urandom_range(1, 45), 0);
    end

    check("protocol_violations", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
